// File: rtl/msrv32_lsu_bus_master.sv
// msrv32_lsu_bus_master: sequential load/store unit driving a single-outstanding
// req/ack data-memory bus. Stores are lane-formatted with byte strobes; loads are
// lane-selected and sign/zero-extended. Optional ACCESS timeout is enabled by
// defining MSRV32_LSU_TIMEOUT_EN (bus_err_out is tied low otherwise).
module msrv32_lsu_bus_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_n_in,
    input  logic              ld_req_in,
    input  logic              st_req_in,
    input  logic [1:0]        size_in,
    input  logic              unsigned_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    input  logic              trap_taken_in,
    output logic              dmem_req_out,
    output logic              dmem_we_out,
    output logic [ADDR_W-1:0] dmem_addr_out,
    output logic [3:0]        dmem_wstrb_out,
    output logic [31:0]       dmem_wdata_out,
    input  logic              dmem_ack_in,
    input  logic [31:0]       dmem_rdata_in,
    output logic              lsu_busy_out,
    output logic              lsu_done_out,
    output logic [31:0]       load_data_out,
    output logic              bus_err_out
);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic [1:0]        r_addr_lo;
    logic              r_unsigned;
    logic              r_done;
    logic [31:0]       r_load_data;

    logic              w_accept;
    logic [3:0]        w_st_wstrb;
    logic [31:0]       w_st_wdata;
    logic [31:0]       w_ld_fmt;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;

    assign w_accept = (r_state == S_IDLE) && (ld_req_in || st_req_in) && !trap_taken_in;

    // Store lane formatting from the incoming request; loads carry no strobes or data
    always_comb begin
        w_st_wstrb = 4'b0000;
        w_st_wdata = 32'h0;
        if (st_req_in) begin
            case (size_in)
                2'b00: begin
                    w_st_wstrb = 4'b0001 << addr_in[1:0];
                    w_st_wdata = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    w_st_wstrb = addr_in[1] ? 4'b1100 : 4'b0011;
                    w_st_wdata = {2{wdata_in[15:0]}};
                end
                default: begin
                    w_st_wstrb = 4'b1111;
                    w_st_wdata = wdata_in;
                end
            endcase
        end
    end

    // Load alignment and extension using the size/offset latched at accept
    always_comb begin
        w_ld_byte = 8'h00;
        case (r_addr_lo)
            2'b00:   w_ld_byte = dmem_rdata_in[7:0];
            2'b01:   w_ld_byte = dmem_rdata_in[15:8];
            2'b10:   w_ld_byte = dmem_rdata_in[23:16];
            default: w_ld_byte = dmem_rdata_in[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (r_size)
            2'b00:   w_ld_fmt = {{24{w_ld_byte[7] & ~r_unsigned}}, w_ld_byte};
            2'b01:   w_ld_fmt = {{16{w_ld_half[15] & ~r_unsigned}}, w_ld_half};
            default: w_ld_fmt = dmem_rdata_in;
        endcase
    end

`ifdef MSRV32_LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;
    assign bus_err_out = r_bus_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign bus_err_out      = 1'b0;
`endif

    // Request FSM: latch the request in IDLE, hold the bus in ACCESS until ack
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0;
            r_size      <= 2'b00;
            r_addr_lo   <= 2'b00;
            r_unsigned  <= 1'b0;
            r_done      <= 1'b0;
            r_load_data <= 32'h0;
`ifdef MSRV32_LSU_TIMEOUT_EN
            r_cnt       <= '0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_ACCESS;
                        r_req      <= 1'b1;
                        r_we       <= st_req_in;
                        r_addr     <= {addr_in[ADDR_W-1:2], 2'b00};
                        r_wstrb    <= w_st_wstrb;
                        r_wdata    <= w_st_wdata;
                        r_size     <= size_in;
                        r_addr_lo  <= addr_in[1:0];
                        r_unsigned <= unsigned_in;
`ifdef MSRV32_LSU_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack_in) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                        r_done  <= !trap_taken_in;
                        if (!r_we && !trap_taken_in) begin
                            r_load_data <= w_ld_fmt;
                        end
`ifdef MSRV32_LSU_TIMEOUT_EN
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= S_IDLE;
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem_req_out   = r_req;
    assign dmem_we_out    = r_we;
    assign dmem_addr_out  = r_addr;
    assign dmem_wstrb_out = r_wstrb;
    assign dmem_wdata_out = r_wdata;
    assign lsu_busy_out   = (r_state == S_ACCESS);
    assign lsu_done_out   = r_done;
    assign load_data_out  = r_load_data;

endmodule

// File: tb/tb_msrv32_lsu_bus_master.sv
// Self-checking bench for msrv32_lsu_bus_master: directed cases followed by
// randomized transactions checked against an arithmetic reference model.
module tb_msrv32_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_req = 1'b0;
    logic        st_req = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        trap = 1'b0;
    logic        req;
    logic        we;
    logic [31:0] daddr;
    logic [3:0]  wstrb;
    logic [31:0] dwdata;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] ld_data;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_ld = 32'h0;

    msrv32_lsu_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .ms_riscv32_mp_clk_in  (clk),
        .ms_riscv32_mp_rst_n_in(rst_n),
        .ld_req_in             (ld_req),
        .st_req_in             (st_req),
        .size_in               (size),
        .unsigned_in           (uns),
        .addr_in               (addr),
        .wdata_in              (wdata),
        .trap_taken_in         (trap),
        .dmem_req_out          (req),
        .dmem_we_out           (we),
        .dmem_addr_out         (daddr),
        .dmem_wstrb_out        (wstrb),
        .dmem_wdata_out        (dwdata),
        .dmem_ack_in           (ack),
        .dmem_rdata_in         (rdata),
        .lsu_busy_out          (busy),
        .lsu_done_out          (done),
        .load_data_out         (ld_data),
        .bus_err_out           (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: strobes and lane data from byte arithmetic
    function automatic logic [3:0] model_strb(input bit is_st, input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!is_st) return 4'd0;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << (off & 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input bit is_st, input logic [1:0] sz, input logic [31:0] d);
        if (!is_st) return 32'd0;
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (8 * (a & 32'd2))) & 32'hFFFF;
            if (!u && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One full transaction: accept, optional wait cycles, ack, completion checks
    task automatic run_txn(input string tag, input bit is_st, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int waits, input bit trap_mid);
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        e_addr = a & 32'hFFFFFFFC;
        e_strb = model_strb(is_st, sz, a);
        e_wd   = model_wdata(is_st, sz, wd);
        st_req = is_st;
        ld_req = !is_st;
        size   = sz;
        uns    = u;
        addr   = a;
        wdata  = wd;
        tick();
        st_req = 1'b0;
        ld_req = 1'b0;
        addr   = $urandom;
        wdata  = $urandom;
        chk({tag, ".acc_ctl"}, {27'd0, req, busy, we, done, bus_err}, {27'd0, 1'b1, 1'b1, is_st, 1'b0, 1'b0});
        chk({tag, ".addr"}, daddr, e_addr);
        chk({tag, ".wstrb"}, {28'd0, wstrb}, {28'd0, e_strb});
        chk({tag, ".wdata"}, dwdata, e_wd);
        for (int w = 0; w < waits; w++) begin
            trap = trap_mid;
            tick();
            chk({tag, ".wait_ctl"}, {28'd0, req, busy, we, done}, {28'd0, 1'b1, 1'b1, is_st, 1'b0});
            chk({tag, ".wait_bus"}, {daddr ^ dwdata, 28'd0, wstrb}, {e_addr ^ e_wd, 28'd0, e_strb});
        end
        ack   = 1'b1;
        rdata = rd;
        trap  = trap_mid;
        tick();
        ack   = 1'b0;
        trap  = 1'b0;
        rdata = $urandom;
        if (!is_st && !trap_mid) exp_ld = model_load(sz, u, a, rd);
        chk({tag, ".done_ctl"}, {29'd0, req, busy, done}, {29'd0, 1'b0, 1'b0, !trap_mid});
        chk({tag, ".load_data"}, ld_data, exp_ld);
        $display("txn %-10s st=%0d sz=%0d u=%0d addr=%h wd=%h rd=%h waits=%0d trap=%0d -> ld=%h",
                 tag, is_st, sz, u, a, wd, rd, waits, trap_mid, ld_data);
    endtask

    task automatic idle_check(input string tag);
        tick();
        chk({tag, ".idle"}, {28'd0, req, busy, done, bus_err}, 32'd0);
        chk({tag, ".idle_ld"}, ld_data, exp_ld);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ctl", {26'd0, req, we, busy, done, bus_err, 1'b0}, 32'd0);
        chk("rst.bus", daddr | dwdata | {28'd0, wstrb}, 32'd0);
        chk("rst.ld", ld_data, 32'd0);
        rst_n = 1'b1;
        idle_check("post_rst");

        // Directed stores
        run_txn("SB", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 32'h0, 0, 1'b0);
        idle_check("SB");
        run_txn("SH", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h00001234, 32'h0, 0, 1'b0);
        run_txn("SW_b2b", 1'b1, 2'd2, 1'b0, 32'h2004, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        run_txn("S11", 1'b1, 2'd3, 1'b0, 32'h2008, 32'hCAFEF00D, 32'h0, 1, 1'b0);

        // Directed loads
        run_txn("LB", 1'b0, 2'd0, 1'b0, 32'h3001, 32'h000080FF, 32'h0, 0, 1'b0);
        run_txn("LBU", 1'b0, 2'd0, 1'b1, 32'h3001, 32'h000080FF, 32'h0, 0, 1'b0);
        run_txn("LH", 1'b0, 2'd1, 1'b0, 32'h3002, 32'h80010000, 32'h0, 0, 1'b0);
        run_txn("LHU", 1'b0, 2'd1, 1'b1, 32'h3000, 32'h1234F00F, 32'h0, 0, 1'b0);
        run_txn("LW_wait5", 1'b0, 2'd2, 1'b0, 32'h3004, 32'h87654321, 32'h0, 5, 1'b0);
        idle_check("LW_wait5");
        run_txn("LB_trap", 1'b0, 2'd0, 1'b0, 32'h3003, 32'h11223344, 32'h0, 2, 1'b1);
        idle_check("LB_trap");
        run_txn("SW_store", 1'b1, 2'd2, 1'b0, 32'h3008, 32'h55AA55AA, 32'h0, 0, 1'b0);

        // Store wins when both requests are high
        ld_req = 1'b1;
        st_req = 1'b1;
        size   = 2'd2;
        addr   = 32'h4000;
        wdata  = 32'h0BADF00D;
        tick();
        ld_req = 1'b0;
        st_req = 1'b0;
        chk("both.we", {31'd0, we}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("both.done", {31'd0, done}, 32'd1);

        // Trap in IDLE suppresses accept; ack in IDLE is ignored
        ld_req = 1'b1;
        trap   = 1'b1;
        tick();
        ld_req = 1'b0;
        trap   = 1'b0;
        chk("trap_idle", {30'd0, req, busy}, 32'd0);
        ack   = 1'b1;
        rdata = 32'hFFFFFFFF;
        tick();
        ack = 1'b0;
        chk("ack_idle", {30'd0, done, busy}, 32'd0);
        chk("ack_idle.ld", ld_data, exp_ld);

`ifdef MSRV32_LSU_TIMEOUT_EN
        // Timeout after 4 ACCESS cycles without ack
        ld_req = 1'b1;
        size   = 2'd2;
        addr   = 32'h5000;
        tick();
        ld_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to.wait", {29'd0, req, busy, bus_err}, {29'd0, 1'b1, 1'b1, 1'b0});
        end
        tick();
        chk("to.err", {28'd0, req, busy, done, bus_err}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        chk("to.ld", ld_data, exp_ld);
        ack   = 1'b1;
        rdata = 32'h12345678;
        tick();
        ack = 1'b0;
        chk("to.late_ack", {28'd0, req, busy, done, bus_err}, 32'd0);
        chk("to.late_ld", ld_data, exp_ld);
`else
        // Without timeout the request stays up indefinitely
        ld_req = 1'b1;
        size   = 2'd2;
        addr   = 32'h5000;
        tick();
        ld_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("noto.wait", {29'd0, req, busy, bus_err}, {29'd0, 1'b1, 1'b1, 1'b0});
        end
        ack   = 1'b1;
        rdata = 32'h12345678;
        tick();
        ack = 1'b0;
        exp_ld = 32'h12345678;
        chk("noto.done", {31'd0, done}, 32'd1);
        chk("noto.ld", ld_data, exp_ld);
`endif

        // Randomized transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            bit          r_st;
            logic [1:0]  r_sz;
            logic [31:0] r_a;
            r_st = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if (r_sz == 2'd1) r_a = r_a & 32'hFFFFFFFE;
            if (r_sz >= 2'd2) r_a = r_a & 32'hFFFFFFFC;
            run_txn("rand", r_st, r_sz, 1'($urandom_range(0, 1)), r_a, $urandom, $urandom,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-ACCESS
        ld_req = 1'b1;
        size   = 2'd2;
        addr   = 32'h6000;
        tick();
        ld_req = 1'b0;
        chk("arst.pre", {30'd0, req, busy}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_ld = 32'h0;
        chk("arst.ctl", {26'd0, req, we, busy, done, bus_err, 1'b0}, 32'd0);
        chk("arst.bus", daddr | dwdata | {28'd0, wstrb}, 32'd0);
        chk("arst.ld", ld_data, 32'd0);
        #1;
        rst_n = 1'b1;
        idle_check("arst.after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msrv32_lsu_bus_master.md
Name: msrv32_lsu_bus_master

Overview:
- Sequential load/store unit that executes the memory requests produced by instruction decode.
- Consumes the load/store request, size and unsigned qualifiers plus the effective address, and drives a single-outstanding req/ack data-memory bus.
- Formats store data into byte lanes with write strobes, and aligns and sign/zero-extends load data.
- Sits between the decode/execute stage and the data memory port; stalls the pipeline while a bus transaction is in flight.

Parameters:
- ADDR_W, 32, data bus address width.
- TIMEOUT_CYCLES, 255, number of cycles in ACCESS without ack before a bus error. Used only when MSRV32_LSU_TIMEOUT_EN is defined.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge
- ms_riscv32_mp_rst_n_in  in  1  reset, asynchronous, active-low
- ld_req_in  in  1  load request, already qualified by not-misaligned
- st_req_in  in  1  store request, i.e. memory write request from decode
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_in  in  1  zero-extend load when 1
- addr_in  in  ADDR_W  effective byte address
- wdata_in  in  32  store source register value
- trap_taken_in  in  1  trap in progress; suppresses accept and completion
- dmem_req_out  out  1  bus request
- dmem_we_out  out  1  1 store, 0 load
- dmem_addr_out  out  ADDR_W  word-aligned address, bits [1:0] = 00
- dmem_wstrb_out  out  4  byte write strobes
- dmem_wdata_out  out  32  lane-formatted store data
- dmem_ack_in  in  1  bus response, one cycle
- dmem_rdata_in  in  32  read data, valid with ack
- lsu_busy_out  out  1  pipeline stall
- lsu_done_out  out  1  one-cycle completion pulse
- load_data_out  out  32  formatted load result
- bus_err_out  out  1  one-cycle timeout pulse

Behaviour:
- Reset: every output is 0, state is IDLE. The asynchronous reset drops dmem_req_out immediately, including mid-transaction.
- State machine has two states, IDLE and ACCESS. lsu_busy_out = (state == ACCESS).
- IDLE, when (ld_req_in | st_req_in) & ~trap_taken_in:
  - Register addr, size, unsigned, we = st_req_in, strobes and formatted wdata.
  - Next state ACCESS with dmem_req_out = 1.
  - If both requests are high, the store wins.
  - With trap_taken_in = 1 the request is ignored.
- ACCESS, all dmem_* outputs held stable until ack.
  - On the edge where dmem_ack_in = 1: state becomes IDLE, dmem_req_out = 0, and lsu_done_out = 1 for exactly one cycle.
  - For a load, load_data_out is updated on that same edge. It holds its value otherwise, and is not changed by stores.
- Latency: request at cycle 0, ACCESS and req at cycle 1, ack at cycle 1 gives done at cycle 2. Each extra wait cycle adds 1.
- Back-to-back: a new request is accepted in IDLE on the same cycle lsu_done_out is high.
- dmem_ack_in while IDLE is ignored.
- trap_taken_in during ACCESS: the transaction is not withdrawn and completes on ack, but lsu_done_out is suppressed and load_data_out is not updated.
- Store formatting, by latched size and addr[1:0]:
  - Byte: byte replicated to all 4 lanes, wstrb = 0001 << addr[1:0].
  - Half: half replicated to both halves, wstrb = 0011 if addr[1] = 0, else 1100.
  - Word (and size 11): wstrb = 1111.
- Load formatting:
  - Byte: lane selected by addr[1:0].
  - Half: upper half if addr[1] = 1, else lower half.
  - Word: passthrough.
  - Byte and half are sign-extended unless unsigned, in which case zero-extended.
- Loads drive wstrb = 0000 and wdata = 0.

Optional Feature:
- MSRV32_LSU_TIMEOUT_EN defined:
  - A counter runs in ACCESS and clears on entry to ACCESS.
  - After TIMEOUT_CYCLES cycles without ack: state becomes IDLE, dmem_req_out = 0, bus_err_out pulses 1 for one cycle, lsu_done_out stays 0, and load_data_out is unchanged.
  - Ack and timeout on the same edge: ack wins.
  - A late ack arriving in IDLE is ignored.
- MSRV32_LSU_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, and bus_err_out is tied to 0.

Test Plan:
- Reset mid-ACCESS (rst_n low while req = 1): dmem_req_out = 0 with no clock edge; all outputs 0; state IDLE after release.
- SB, addr = 0x1003, wdata = 0x000000A5, ack 1 cycle after req: dmem_addr = 0x1000, wstrb = 1000, wdata = 0xA5A5A5A5, done at cycle 2.
- SH, addr = 0x2002, wdata = 0x1234: wstrb = 1100, wdata = 0x12341234. Then SW at 0x2004: wstrb = 1111, accepted back-to-back on the done cycle.
- LB, addr = 0x3001, rdata = 0x0000_80FF:
  - Signed: load_data_out = 0xFFFFFF80.
  - Repeat as LBU: 0x00000080.
  - LH at addr 0x3002, rdata = 0x8001_0000: 0xFFFF8001.
- Ack held off 5 cycles: busy = 1 and the bus outputs are stable for all 5 cycles; done occurs once. trap_taken_in = 1 during ACCESS: done is suppressed and load_data_out is unchanged.
- With MSRV32_LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack: bus_err_out pulses once after 4 ACCESS cycles, req drops, and a late ack is ignored. Without the macro, req stays high.
